// File: rtl/multi_input_sum_sequencer.sv
// Frame summer that folds NUM_INPUT signed samples through one shared LANES-input
// registered adder, accumulating one partial sum per accepted beat.

module lane_sum_adder #(
  parameter int NUM_INPUT     = 2,
  parameter int DATA_WIDTH_IN = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 ena,
  input  logic signed [DATA_WIDTH_IN-1:0]                      din [NUM_INPUT],
  output logic signed [DATA_WIDTH_IN+$clog2(NUM_INPUT)-1:0]    sum
);

  localparam int PW = DATA_WIDTH_IN + $clog2(NUM_INPUT);

  logic signed [PW-1:0] total;

  always_comb begin
    total = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      total = total + PW'(din[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (ena) begin
      sum <= total;
    end
  end

endmodule

module multi_input_sum_sequencer #(
  parameter int NUM_INPUT     = 8,
  parameter int DATA_WIDTH_IN = 16,
  parameter int LANES         = 2
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               s_valid,
  output logic                                               s_ready,
  input  logic signed [DATA_WIDTH_IN-1:0]                    s_data [LANES],
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic signed [DATA_WIDTH_IN+$clog2(NUM_INPUT)-1:0]  m_data,
  output logic                                               busy
);

  localparam int BEATS = NUM_INPUT / LANES;
  localparam int PW    = DATA_WIDTH_IN + $clog2(LANES);
  localparam int OW    = DATA_WIDTH_IN + $clog2(NUM_INPUT);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        beat_cnt, beat_next;
  logic                 ena;
  logic                 pv;
  logic signed [PW-1:0] psum;
  logic signed [OW-1:0] acc;

  assign s_ready = (state == ACC) && !rst;
  assign ena     = s_valid && s_ready;
  assign m_valid = (state == OUT);
  assign m_data  = (state == OUT) ? acc : '0;
  assign busy    = (state != ACC) || (beat_cnt != '0);

  lane_sum_adder #(
    .NUM_INPUT     (LANES),
    .DATA_WIDTH_IN (DATA_WIDTH_IN)
  ) u_adder (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .din (s_data),
    .sum (psum)
  );

  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    case (state)
      ACC: begin
        if (ena) begin
          if (beat_cnt == CW'(BEATS - 1)) begin
            beat_next  = '0;
            state_next = DRAIN;
          end else begin
            beat_next = beat_cnt + CW'(1);
          end
        end
      end
      DRAIN:   state_next = OUT;
      OUT:     if (m_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_next;
    end
  end

  // The adder output lags its enable by one cycle, so pv gates accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv  <= 1'b0;
      acc <= '0;
    end else begin
      pv <= ena;
      if (pv) begin
        acc <= acc + OW'(psum);
      end else if (state == OUT && m_ready) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: doc/multi_input_sum_sequencer.md
Name: multi_input_sum_sequencer

Overview:
Time-multiplexed controller that computes the signed sum of NUM_INPUT samples by reusing one narrow LANES-input registered adder over several passes. Frames arrive as a valid/ready stream of LANES-sample beats. The block drives the shared adder's enable, accumulates its partial sums, and presents one full-width result per frame on a valid/ready output. It sits in DSP datapaths where a full NUM_INPUT-wide adder tree is too costly.

Parameters:
NUM_INPUT, 8, samples per frame; must be a multiple of LANES.
DATA_WIDTH_IN, 16, signed sample width; must be > 0.
LANES, 2, samples per beat, which is also the input count of the shared adder; must be >= 1.
Derived: BEATS = NUM_INPUT/LANES; PW = DATA_WIDTH_IN+$clog2(LANES); OW = DATA_WIDTH_IN+$clog2(NUM_INPUT).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  beat valid
s_ready  out  1  beat accept
s_data  in  LANES x DATA_WIDTH_IN signed (unpacked array)  one beat of samples
m_valid  out  1  result valid
m_ready  in  1  result accept
m_data  out  OW signed  frame sum
busy  out  1  frame in progress: state != ACC or beat_cnt != 0

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Shared adder:
  - Instantiated internally with NUM_INPUT=LANES and DATA_WIDTH_IN=DATA_WIDTH_IN.
  - Its ena = s_valid && s_ready.
  - Its registered PW-bit sum is valid exactly one cycle after ena.
- Registers:
  - state in {ACC, DRAIN, OUT}.
  - beat_cnt, 0..BEATS-1.
  - pv (partial valid) = ena delayed by one cycle.
  - acc (OW bits signed).
- Reset (rst=1 at an edge):
  - state=ACC, beat_cnt=0, pv=0, acc=0, m_valid=0, m_data=0.
  - s_ready is 0 while rst is high.
  - Reset mid-frame discards all partials. The adder's stale output is ignored because pv=0.
- s_ready = (state==ACC) && !rst. m_valid = (state==OUT). m_data = acc while in OUT.
- Accumulate: on any cycle with pv=1, acc <= acc + sign_extend(adder_sum to OW). This applies in both ACC and DRAIN.
- ACC state:
  - On each handshake, beat_cnt increments.
  - On the handshake where beat_cnt==BEATS-1: beat_cnt <= 0 and state <= DRAIN.
  - Gaps (s_valid=0) are allowed anywhere; no timeout.
- DRAIN: lasts exactly 1 cycle. The final partial is accumulated (pv=1), then state <= OUT.
- OUT:
  - Holds m_valid=1 and a stable m_data until m_ready=1.
  - On the handshake: acc <= 0, state <= ACC.
  - s_ready is 0 throughout OUT, so there is no frame overlap.
- Latency: last-beat handshake at cycle T gives m_valid=1 from cycle T+2. Output handshake at cycle U gives s_ready=1 at U+1.
- Throughput: with no stalls, one frame every BEATS+2 cycles.
- Arithmetic: two's complement throughout, no saturation. OW guarantees no overflow for any inputs.
- LANES==NUM_INPUT: BEATS=1, so ACC -> DRAIN after a single beat.
- LANES==1: PW=DATA_WIDTH_IN.
- m_ready asserted while not in OUT has no effect.

Test Plan (NUM_INPUT=8, DATA_WIDTH_IN=16, LANES=2, OW=19):
- Basic frame: beats (1,2),(3,4),(5,6),(7,8) back-to-back, m_ready=1 -> m_data=36; m_valid exactly 2 cycles after 4th handshake, high for 1 cycle.
- Extremes: all samples -32768 -> m_data=-262144 (19'h40000). All samples 32767 -> 262136. Mixed (32767,-32768)x4 -> -4.
- Gaps and backpressure: s_valid toggling 1/0 during the frame, then m_ready held 0 for 5 cycles -> m_data=36 stable the whole time, s_ready=0 throughout OUT, s_ready=1 the cycle after the m_ready handshake.
- Back-to-back frames: frame A = 1..8, frame B = all -1 -> outputs 36 then -8; acc is not carried over between frames.
- Reset mid-frame: rst for 1 cycle after 2 beats of (100,100) -> busy=0 and m_valid=0 after reset; next full frame 1..8 -> 36.
- Reset during OUT: rst while m_valid=1 -> m_valid=0 and m_data=0 next cycle; s_ready=1 the following cycle.
